// File: rtl/voice_pkg.sv
// Shared types and defaults for the polyphonic voice allocator.
// Latency: n/a. This file holds only constants and types.
// Backpressure: n/a.
package voice_pkg;

  localparam int NVOICES_DFLT = 4;
  localparam int NOTE_W_DFLT  = 7;
  localparam int RANK_W       = $clog2(NVOICES_DFLT);

  // IDLE accepts events. STEAL_OFF is the cycle where the stolen voice's
  // gate_off is visible. STEAL_ON is the cycle where its gate_on is visible.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STEAL_OFF = 2'd1,
    STEAL_ON  = 2'd2
  } state_t;

endpackage

// File: rtl/voice_allocator_if.sv
// Event handshake and per-voice output bundle between the MIDI parser and the voice channels.
// Latency: n/a (wires only).
// Backpressure: the event side is held by upstream until evt_ready is seen.
// Ports: note_on/note_off/note_num/note_vel/voice_idle flow into the allocator;
//        evt_ready/evt_drop/voice_note/voice_vel/gate_on/gate_off/voice_held flow out.
interface voice_allocator_if
  import voice_pkg::*;
#(
  parameter int NVOICES = NVOICES_DFLT,
  parameter int NOTE_W  = NOTE_W_DFLT
);
  logic                      note_on;
  logic                      note_off;
  logic [NOTE_W-1:0]         note_num;
  logic [NOTE_W-1:0]         note_vel;
  logic [NVOICES-1:0]        voice_idle;
  logic                      evt_ready;
  logic                      evt_drop;
  logic [NVOICES*NOTE_W-1:0] voice_note;
  logic [NVOICES*NOTE_W-1:0] voice_vel;
  logic [NVOICES-1:0]        gate_on;
  logic [NVOICES-1:0]        gate_off;
  logic [NVOICES-1:0]        voice_held;

  modport master (
    output note_on, note_off, note_num, note_vel, voice_idle,
    input  evt_ready, evt_drop, voice_note, voice_vel, gate_on, gate_off, voice_held
  );

  modport slave (
    input  note_on, note_off, note_num, note_vel, voice_idle,
    output evt_ready, evt_drop, voice_note, voice_vel, gate_on, gate_off, voice_held
  );
endinterface

// File: rtl/voice_pick.sv
// Combinational voice selection: held-note match, free voice, and steal candidate.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when the results are used.
// Ports: held, voice_idle, notes, ranks, note_num in; match_idx/vld, free_idx/vld, steal_idx out.
module voice_pick #(
  parameter int NVOICES = 4,
  parameter int NOTE_W  = 7,
  parameter int IDX_W   = $clog2(NVOICES)
) (
  input  logic [NVOICES-1:0]        held,
  input  logic [NVOICES-1:0]        voice_idle,
  input  logic [NVOICES*NOTE_W-1:0] notes,
  input  logic [NVOICES*IDX_W-1:0]  ranks,
  input  logic [NOTE_W-1:0]         note_num,
  output logic [IDX_W-1:0]          match_idx,
  output logic                      match_vld,
  output logic [IDX_W-1:0]          free_idx,
  output logic                      free_vld,
  output logic [IDX_W-1:0]          steal_idx
);

  logic             any_unheld;
  logic             found;
  logic [IDX_W-1:0] best;

  always_comb begin
    match_idx  = '0;
    match_vld  = 1'b0;
    free_idx   = '0;
    free_vld   = 1'b0;
    steal_idx  = '0;
    found      = 1'b0;
    best       = '0;
    any_unheld = ~&held;

    // Scan downwards so the lowest matching index is the one left standing.
    for (int i = NVOICES - 1; i >= 0; i--) begin
      if (held[i] && (notes[i*NOTE_W +: NOTE_W] == note_num)) begin
        match_vld = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!held[i] && voice_idle[i]) begin
        free_vld = 1'b1;
        free_idx = IDX_W'(i);
      end
    end

    // Oldest released voice if any exists, otherwise the oldest voice overall.
    // Ranks are a permutation, so there are never ties.
    for (int i = 0; i < NVOICES; i++) begin
      if ((!any_unheld || !held[i]) &&
          (!found || (ranks[i*IDX_W +: IDX_W] > best))) begin
        found     = 1'b1;
        best      = ranks[i*IDX_W +: IDX_W];
        steal_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: assigns note events to voices and steals the oldest voice when none is free.
// Latency: pulses and register updates appear 1 clk after the accepting edge. A steal gives gate_off, then gate_on on the next ce edge.
// Backpressure: evt_ready drops for the two steal cycles. Upstream holds its request until accepted.
// Ports: clk, rst (sync, active high), ce (clock enable), bus (voice_allocator_if.slave).
module voice_allocator
  import voice_pkg::*;
#(
  parameter int NVOICES = NVOICES_DFLT,
  parameter int NOTE_W  = NOTE_W_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  voice_allocator_if.slave   bus
);

  localparam int IDX_W = $clog2(NVOICES);

  state_t                    state, state_nxt;
  logic [NVOICES-1:0]        held;
  logic [NOTE_W-1:0]         note_r [NVOICES];
  logic [NOTE_W-1:0]         vel_r  [NVOICES];
  logic [IDX_W-1:0]          rank   [NVOICES];
  logic [IDX_W-1:0]          tgt;
  logic [NOTE_W-1:0]         tgt_note, tgt_vel;
  logic [NVOICES-1:0]        gate_on_r, gate_off_r;
  logic                      drop_r;

  logic [NVOICES*NOTE_W-1:0] notes_flat, vels_flat;
  logic [NVOICES*IDX_W-1:0]  ranks_flat;
  logic [IDX_W-1:0]          match_idx, free_idx, steal_idx;
  logic                      match_vld, free_vld;

  logic [NVOICES-1:0]        on_nxt, off_nxt, clr_held, set_held;
  logic                      drop_nxt, wr_en, promote, lat_tgt;
  logic [IDX_W-1:0]          wr_idx, promote_idx;
  logic [NOTE_W-1:0]         wr_note, wr_vel;

  always_comb begin
    for (int i = 0; i < NVOICES; i++) begin
      notes_flat[i*NOTE_W +: NOTE_W] = note_r[i];
      vels_flat[i*NOTE_W +: NOTE_W]  = vel_r[i];
      ranks_flat[i*IDX_W +: IDX_W]   = rank[i];
    end
  end

  voice_pick #(.NVOICES(NVOICES), .NOTE_W(NOTE_W), .IDX_W(IDX_W)) u_pick (
    .held       (held),
    .voice_idle (bus.voice_idle),
    .notes      (notes_flat),
    .ranks      (ranks_flat),
    .note_num   (bus.note_num),
    .match_idx  (match_idx),
    .match_vld  (match_vld),
    .free_idx   (free_idx),
    .free_vld   (free_vld),
    .steal_idx  (steal_idx)
  );

  always_ff @(posedge clk) begin
    if (rst)     state <= IDLE;
    else if (ce) state <= state_nxt;
  end

  // Next state plus the update to commit on the next ce edge. The steal's
  // gate_off is issued on the accepting edge, so it is visible while in
  // STEAL_OFF. The gate_on is issued on the STEAL_OFF edge.
  always_comb begin
    state_nxt   = state;
    on_nxt      = '0;
    off_nxt     = '0;
    clr_held    = '0;
    set_held    = '0;
    drop_nxt    = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = tgt;
    wr_note     = tgt_note;
    wr_vel      = tgt_vel;
    promote     = 1'b0;
    promote_idx = tgt;
    lat_tgt     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.note_off) begin
          if (match_vld) begin
            off_nxt[match_idx]  = 1'b1;
            clr_held[match_idx] = 1'b1;
          end
          drop_nxt = bus.note_on;
        end else if (bus.note_on) begin
          if (match_vld) begin
            on_nxt[match_idx] = 1'b1;
            wr_en   = 1'b1;
            wr_idx  = match_idx;
            wr_note = bus.note_num;
            wr_vel  = bus.note_vel;
          end else if (free_vld) begin
            on_nxt[free_idx]   = 1'b1;
            set_held[free_idx] = 1'b1;
            wr_en       = 1'b1;
            wr_idx      = free_idx;
            wr_note     = bus.note_num;
            wr_vel      = bus.note_vel;
            promote     = 1'b1;
            promote_idx = free_idx;
          end else begin
            lat_tgt             = 1'b1;
            off_nxt[steal_idx]  = 1'b1;
            clr_held[steal_idx] = 1'b1;
            state_nxt           = STEAL_OFF;
          end
        end
      end
      STEAL_OFF: begin
        on_nxt[tgt]   = 1'b1;
        set_held[tgt] = 1'b1;
        wr_en         = 1'b1;
        promote       = 1'b1;
        state_nxt     = STEAL_ON;
      end
      STEAL_ON: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held       <= '0;
      gate_on_r  <= '0;
      gate_off_r <= '0;
      drop_r     <= 1'b0;
      tgt        <= '0;
      tgt_note   <= '0;
      tgt_vel    <= '0;
      for (int i = 0; i < NVOICES; i++) begin
        note_r[i] <= '0;
        vel_r[i]  <= '0;
        rank[i]   <= IDX_W'(i);
      end
    end else begin
      // Pulses are rebuilt every clk, so a ce=0 cycle always shows zeros.
      gate_on_r  <= ce ? on_nxt   : '0;
      gate_off_r <= ce ? off_nxt  : '0;
      drop_r     <= ce & drop_nxt;
      if (ce) begin
        held <= (held & ~clr_held) | set_held;
        if (wr_en) begin
          note_r[wr_idx] <= wr_note;
          vel_r[wr_idx]  <= wr_vel;
        end
        if (lat_tgt) begin
          tgt      <= steal_idx;
          tgt_note <= bus.note_num;
          tgt_vel  <= bus.note_vel;
        end
        if (promote) begin
          for (int i = 0; i < NVOICES; i++) begin
            if (rank[i] < rank[promote_idx]) rank[i] <= rank[i] + 1'b1;
          end
          rank[promote_idx] <= '0;
        end
      end
    end
  end

  assign bus.evt_ready  = (state == IDLE);
  assign bus.evt_drop   = drop_r;
  assign bus.gate_on    = gate_on_r;
  assign bus.gate_off   = gate_off_r;
  assign bus.voice_held = held;
  assign bus.voice_note = notes_flat;
  assign bus.voice_vel  = vels_flat;

endmodule
